// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device with the request-to-send sequence:
// clock inhibit, start bit, eight data bits LSB first, odd parity, stop bit,
// then the device ack. Both lines are open-drain and are driven through
// output enables (1 = pull the line low).
// The pad inputs pass through a 2-FF synchronizer and a FILT-sample glitch
// filter. Falling edges of the filtered clock pace every bit after the start bit.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYC = 5760,    // clock-low inhibit, in clk cycles
   parameter int unsigned START_TMO   = 720000,  // release -> first device fall
   parameter int unsigned XFER_TMO    = 96000,   // first device fall -> idle bus
   parameter int unsigned FILT        = 4        // equal samples needed to flip a line
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       busy,
   output logic       done,
   output logic       error
);

   // The timer is shared by all timed states, so it is sized for the longest limit.
   localparam int unsigned TMAX_A = (START_TMO > XFER_TMO) ? START_TMO : XFER_TMO;
   localparam int unsigned TMAX   = (TMAX_A > INHIBIT_CYC) ? TMAX_A : INHIBIT_CYC;
   localparam int unsigned TW     = $clog2(TMAX + 1);
   localparam int unsigned FW     = $clog2(FILT + 1);

   // Every timed state exits into a one-cycle state: RELEASE after INHIBIT and
   // FAIL after a timeout. The terminal count is therefore LIMIT-2. This keeps
   // the clock inhibited for exactly INHIBIT_CYC cycles. It also puts the done
   // pulse of a start timeout exactly START_TMO cycles after the clock is released.
   localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 2);
   localparam logic [TW-1:0] START_LAST = TW'(START_TMO - 2);
   localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TMO - 2);
   localparam logic [FW-1:0] FILT_LAST  = FW'(FILT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INHIBIT,
      S_RELEASE,
      S_WAIT_FIRST,
      S_DATA,
      S_STOP,
      S_ACK,
      S_WAIT_IDLE,
      S_FAIL,
      S_DONE
   } state_e;

   // ------------------------------------------------------------------------
   // Input path: synchronizer, glitch filter, falling-edge detect.
   // Bit 0 carries the clock line and bit 1 carries the data line.
   // ------------------------------------------------------------------------
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    filt_q;
   logic [FW-1:0] fcnt_q [2];
   logic          clk_prev_q;
   logic          fall_clk;

   // Synchronize both pad inputs, then flip each filtered line only after
   // FILT consecutive samples disagree with its current value.
   // NOTE: sequential state is written with non-blocking assignments only.
   // Every flop then sees the pre-edge value of every other flop, with no
   // dependence on statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the filter counters are a two-entry register array, not a RAM.
         // Resetting them is cheap, and it keeps the filter state defined while
         // the lines float high after reset.
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         filt_q     <= 2'b11;
         fcnt_q[0]  <= '0;
         fcnt_q[1]  <= '0;
         clk_prev_q <= 1'b1;
      end else begin
         sync1_q    <= {ps2_dat_i, ps2_clk_i};
         sync2_q    <= sync1_q;
         clk_prev_q <= filt_q[0];
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == FILT_LAST) begin
               filt_q[i] <= sync2_q[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + FW'(1);
            end
         end
      end
   end

   // One-cycle event for a filtered clock transition from 1 to 0.
   assign fall_clk = clk_prev_q & ~filt_q[0];

   // ------------------------------------------------------------------------
   // Transfer FSM and its datapath
   // ------------------------------------------------------------------------
   state_e        state_q,  state_d;
   logic [TW-1:0] timer_q,  timer_d;
   logic [7:0]    shift_q,  shift_d;
   logic          par_q,    par_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic          dat_q,    dat_d;     // pending data-line pull-down
   logic          err_q,    err_d;
   logic          xfer_exp;

   // State register and datapath registers. An asynchronous reset releases
   // the lines at once, even in the middle of a transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         bitcnt_q <= '0;
         dat_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         bitcnt_q <= bitcnt_d;
         dat_q    <= dat_d;
         err_q    <= err_d;
      end
   end

   // The transfer timeout runs continuously from the first device edge.
   // It is not restarted by later edges.
   assign xfer_exp = (timer_q == XFER_LAST);

   // Next-state and datapath logic. The timer free-runs unless a state clears it.
   always_comb begin
      // NOTE: every signal assigned here gets a default first. No path can
      // leave it unassigned, so no latch is inferred.
      state_d  = state_q;
      timer_d  = timer_q + TW'(1);
      shift_d  = shift_q;
      par_d    = par_q;
      bitcnt_d = bitcnt_q;
      dat_d    = dat_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            dat_d   = 1'b0;
            if (tx_start) begin
               shift_d  = tx_data;
               par_d    = ~^tx_data;          // odd parity over the data byte
               bitcnt_d = '0;
               err_d    = 1'b0;
               state_d  = S_INHIBIT;
            end
         end

         S_INHIBIT: begin
            if (timer_q == INH_LAST) begin
               dat_d   = 1'b1;                // start bit: data pulled low
               state_d = S_RELEASE;
            end
         end

         S_RELEASE: begin
            timer_d = '0;
            state_d = S_WAIT_FIRST;
         end

         S_WAIT_FIRST: begin
            if (fall_clk) begin
               dat_d    = ~shift_q[0];
               bitcnt_d = 4'd1;
               timer_d  = '0;
               state_d  = S_DATA;
            end else if (timer_q == START_LAST) begin
               state_d = S_FAIL;
            end
         end

         S_DATA: begin
            if (xfer_exp) begin
               state_d = S_FAIL;
            end else if (fall_clk) begin
               if (bitcnt_q == 4'd8) begin
                  dat_d   = ~par_q;
                  state_d = S_STOP;
               end else begin
                  dat_d    = ~shift_q[bitcnt_q[2:0]];
                  bitcnt_d = bitcnt_q + 4'd1;
               end
            end
         end

         S_STOP: begin
            if (xfer_exp) begin
               state_d = S_FAIL;
            end else if (fall_clk) begin
               dat_d   = 1'b0;                // stop bit: line released high
               state_d = S_ACK;
            end
         end

         S_ACK: begin
            if (xfer_exp) begin
               state_d = S_FAIL;
            end else if (fall_clk) begin
               err_d   = filt_q[1];           // device holds data low to ack
               state_d = S_WAIT_IDLE;
            end
         end

         S_WAIT_IDLE: begin
            if (xfer_exp) begin
               state_d = S_FAIL;
            end else if (&filt_q) begin
               state_d = S_DONE;
            end
         end

         S_FAIL: begin
            dat_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
         end

         S_DONE: begin
            timer_d = '0;
            dat_d   = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode. Only the states that own the bus may pull a line.
   always_comb begin
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      case (state_q)
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
         end
         S_RELEASE: begin
            ps2_clk_oe = 1'b1;
            ps2_dat_oe = dat_q;
         end
         S_WAIT_FIRST, S_DATA, S_STOP, S_ACK: begin
            ps2_dat_oe = dat_q;
         end
         default: begin
            ps2_clk_oe = 1'b0;
            ps2_dat_oe = 1'b0;
         end
      endcase
      busy  = (state_q != S_IDLE);
      done  = (state_q == S_DONE);
      error = err_q;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx. A behavioural PS/2 device drives the lines.
// Expected bit values and the expected error flag are queued when a command is
// issued. They are popped when the device samples a bit or when done is seen.
module tb_ps2_host_tx;

   localparam int INHIBIT_CYC = 5760;
   localparam int START_TMO   = 3000;
   localparam int XFER_TMO    = 1500;
   localparam int FILT        = 4;
   localparam int HALF        = 30;    // device half clock period, in clk cycles
   localparam int GAP         = 40;    // device delay after the clock is released
   localparam int DONE_BUDGET = START_TMO + XFER_TMO + 500;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk_i, ps2_dat_i;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       busy, done, error;

   logic       dev_clk_hi = 1'b1;      // device releases the clock line
   logic       dev_dat_lo = 1'b0;      // device pulls the data line low

   int         n_cmp = 0;
   int         n_err = 0;
   logic       exp_oe_q[$];
   logic       exp_err_q[$];
   int         k;

   // Open-drain bus: a line is low if either side pulls it low.
   assign ps2_clk_i = ~ps2_clk_oe & dev_clk_hi;
   assign ps2_dat_i = ~ps2_dat_oe & ~dev_dat_lo;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYC (INHIBIT_CYC),
      .START_TMO   (START_TMO),
      .XFER_TMO    (XFER_TMO),
      .FILT        (FILT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue a command and queue its expected line values: eight data bits LSB
   // first, the parity bit (odd parity) and the released stop bit.
   task automatic start_tx(input logic [7:0] b, input logic exp_err);
      logic par;
      @(negedge clk);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      tx_data  = 8'h00;
      check("busy_after_start", busy, 1'b1);
      for (int i = 0; i < 8; i++) exp_oe_q.push_back(~b[i]);
      par = 1'b1;
      for (int i = 0; i < 8; i++) par = par ^ b[i];
      exp_oe_q.push_back(~par);
      exp_oe_q.push_back(1'b0);
      exp_err_q.push_back(exp_err);
   endtask

   // Device model. It measures the inhibit, then produces n_edges clock pulses
   // and samples the host data enable late in each low phase. It can inject a
   // tx_start while the host is busy, or pulse reset in the middle of a transfer.
   task automatic run_device(input int n_edges, input bit ack, input int inject_at,
                             input int abort_at);
      int   cnt;
      logic e;
      cnt = 0;
      while (ps2_clk_oe === 1'b1 && cnt < INHIBIT_CYC + 100) begin
         cnt++;
         @(negedge clk);
      end
      check("inhibit_len", cnt, INHIBIT_CYC);
      check("start_bit", ps2_dat_oe, 1'b1);
      if (n_edges == 0) return;
      repeat (GAP) @(negedge clk);
      check("start_bit_held", ps2_dat_oe, 1'b1);
      for (int ed = 1; ed <= n_edges; ed++) begin
         dev_clk_hi = 1'b0;
         repeat (HALF) @(negedge clk);
         if (ed <= 10) begin
            e = 1'b0;
            if (exp_oe_q.size() > 0) e = exp_oe_q.pop_front();
            check($sformatf("bit_oe_edge%0d", ed), ps2_dat_oe, e);
         end
         if (ed == abort_at) begin
            #2 reset_n = 1'b0;
            #1;
            check("abort_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
            check("abort_busy", busy, 1'b0);
            check("abort_error", error, 1'b0);
            dev_clk_hi = 1'b1;
            dev_dat_lo = 1'b0;
            repeat (5) @(negedge clk);
            reset_n = 1'b1;
            repeat (5) @(negedge clk);
            return;
         end
         dev_clk_hi = 1'b1;
         if (ack && ed == 10) dev_dat_lo = 1'b1;
         if (ed == 11) dev_dat_lo = 1'b0;
         if (ed == n_edges) return;
         if (ed == inject_at) begin
            tx_data  = 8'h55;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            tx_data  = 8'h00;
            repeat (HALF - 1) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
      end
   endtask

   // Wait for the done pulse, check the queued result, then confirm that the
   // host releases the bus and produces no further done pulse.
   task automatic wait_done(output int lat);
      int   extra;
      logic e;
      lat   = 0;
      extra = 0;
      while (done !== 1'b1 && lat < DONE_BUDGET) begin
         @(negedge clk);
         lat++;
      end
      check("done_seen", done, 1'b1);
      e = 1'b0;
      if (exp_err_q.size() > 0) e = exp_err_q.pop_front();
      check("error_at_done", error, e);
      check("busy_at_done", busy, 1'b1);
      @(negedge clk);
      check("busy_after_done", busy, 1'b0);
      check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      repeat (100) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      check("single_done", extra, 0);
      check("error_held", error, e);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      check("rst_flags", {busy, done, error}, 3'b000);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // 0xED with ack
      start_tx(8'hED, 1'b0);
      run_device(11, 1'b1, 0, 0);
      wait_done(k);

      // 0x00 with ack
      start_tx(8'h00, 1'b0);
      run_device(11, 1'b1, 0, 0);
      wait_done(k);

      // no ack: data left high on the 11th edge
      start_tx(8'hA7, 1'b1);
      run_device(11, 1'b0, 0, 0);
      wait_done(k);

      // device never clocks: start timeout, timed from the clock release
      start_tx(8'h12, 1'b1);
      run_device(0, 1'b1, 0, 0);
      wait_done(k);
      check("start_tmo_latency", k, START_TMO);
      exp_oe_q.delete();

      // device stops after 4 edges: transfer timeout
      start_tx(8'h3C, 1'b1);
      run_device(4, 1'b1, 0, 0);
      wait_done(k);
      exp_oe_q.delete();

      // tx_start of 0x55 while busy sending 0xED must be ignored
      start_tx(8'hED, 1'b0);
      run_device(11, 1'b1, 3, 0);
      wait_done(k);

      // reset pulsed in the middle of DATA
      start_tx(8'hED, 1'b0);
      run_device(11, 1'b1, 0, 5);
      exp_oe_q.delete();
      exp_err_q.delete();
      repeat (50) @(negedge clk);
      check("post_reset_idle", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
